mem_bus_arbiter: RTL and testbench

Sequences and shares the single external memory bus (Address_Bus, Data_Bus, Rw, En, ALE) between two requesters: the CPU control unit and a program loader/debug port. Each request becomes one multi-cycle bus transaction with an address phase (ALE), a data phase (En) and a one-cycle acknowledge. The block sits between the cpu/Datapath pair and the memory pins, and is the only driver of the external bus.

---
 rtl/bus_arb_pkg.sv | 23 ++
 rtl/bus_arb_pick.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared definitions for the external memory bus arbiter: FSM state
//   encoding, requester IDs, bus direction encoding and wait-counter width.
//   No ports (package).

package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CNT_W = 4;

endpackage

// File: rtl/bus_arb_pick.sv
// bus_arb_pick
//   Combinational grant selection between the CPU and loader requesters.
//   Build option: BUS_ARB_RR_EN
//     defined   -> on a tie, grant the requester that did not own the bus last
//     undefined -> fixed priority, CPU wins ties
//   Ports:
//     cpu_req_i     in  1  CPU request
//     ldr_req_i     in  1  loader request
//     last_owner_i  in  1  most recent owner (REQ_CPU / REQ_LDR)
//     grant_o       out 1  selected requester ID (only meaningful if a req is high)

module bus_arb_pick
  import bus_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic ldr_req_i,
  input  logic last_owner_i,
  output logic grant_o
);

`ifdef BUS_ARB_RR_EN
  always_comb begin
    grant_o = REQ_CPU;
    if (cpu_req_i && ldr_req_i) begin
      grant_o = ~last_owner_i;
    end else if (ldr_req_i) begin
      grant_o = REQ_LDR;
    end
  end
`else
  // Fixed priority has no use for the previous owner.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  always_comb begin
    grant_o = REQ_CPU;
    if (!cpu_req_i && ldr_req_i) begin
      grant_o = REQ_LDR;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single external memory bus between the CPU control unit and
//   the program loader/debug port. Each request becomes one transaction:
//   address phase (ALE), WAIT_CYCLES-long data phase (En), one-cycle ack.
//   Build option: BUS_ARB_RR_EN (round-robin tie-break, see bus_arb_pick).
//   Parameter: WAIT_CYCLES (1..15) data-phase length in cycles.
//   Ports:
//     clk, rst                         clock, async active-high reset
//     cpu_req/rw/addr/wdata      in    CPU request, direction, address, data
//     cpu_ack, cpu_rdata         out   CPU done pulse, last CPU read data
//     ldr_req/rw/addr/wdata      in    loader request side
//     ldr_ack, ldr_rdata         out   loader done pulse, last loader read data
//     owner                      out   current / most recent owner (0 CPU, 1 loader)
//     Address_Bus, Rw            out   registered address and direction
//     Data_Bus                   inout driven only in the data phase of a write
//     En, ALE                    out   data-phase enable, address latch enable
//
//   state | meaning
//   IDLE  | arbitrate; latch winner's addr/rw/wdata when any req is high
//   ADDR  | address phase, ALE high, load wait counter
//   DATA  | data phase, En high, count down; sample read data at count 0
//   ACK   | pulse winner's ack, bus released

module mem_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       ldr_req,
  input  logic       ldr_rw,
  input  logic [7:0] ldr_addr,
  input  logic [7:0] ldr_wdata,
  output logic       ldr_ack,
  output logic [7:0] ldr_rdata,
  output logic       owner,
  output logic [7:0] Address_Bus,
  inout  wire  [7:0] Data_Bus,
  output logic       Rw,
  output logic       En,
  output logic       ALE
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       addr_q;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       cpu_rdata_q;
  logic [7:0]       ldr_rdata_q;

  logic any_req;
  logic grant;
  logic cnt_tc;
  logic drive_en;

  assign any_req = cpu_req | ldr_req;
  assign cnt_tc  = (cnt_q == '0);

  bus_arb_pick u_pick (
    .cpu_req_i    (cpu_req),
    .ldr_req_i    (ldr_req),
    .last_owner_i (owner_q),
    .grant_o      (grant)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = ADDR;
      ADDR: state_d = DATA;
      DATA: if (cnt_tc) state_d = ACK;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction registers: latched once in IDLE so later input changes are
  // ignored; owner_q doubles as the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      rw_q        <= RW_READ;
      wdata_q     <= '0;
      owner_q     <= REQ_CPU;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= grant;
            if (grant == REQ_LDR) begin
              addr_q  <= ldr_addr;
              rw_q    <= ldr_rw;
              wdata_q <= ldr_wdata;
            end else begin
              addr_q  <= cpu_addr;
              rw_q    <= cpu_rw;
              wdata_q <= cpu_wdata;
            end
          end
        end
        ADDR: cnt_q <= WAIT_LOAD;
        DATA: begin
          if (cnt_tc) begin
            if (rw_q == RW_READ) begin
              if (owner_q == REQ_LDR) ldr_rdata_q <= Data_Bus;
              else                    cpu_rdata_q <= Data_Bus;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: strobes decode straight from the registered state, so they
  // drop in the same cycle an async reset hits.
  always_comb begin
    ALE      = 1'b0;
    En       = 1'b0;
    cpu_ack  = 1'b0;
    ldr_ack  = 1'b0;
    drive_en = 1'b0;
    unique case (state_q)
      ADDR: ALE = 1'b1;
      DATA: begin
        En       = 1'b1;
        drive_en = (rw_q == RW_WRITE);
      end
      ACK: begin
        cpu_ack = (owner_q == REQ_CPU);
        ldr_ack = (owner_q == REQ_LDR);
      end
      default: ;
    endcase
  end

  assign Data_Bus    = drive_en ? wdata_q : 8'hzz;
  assign Address_Bus = addr_q;
  assign Rw          = rw_q;
  assign owner       = owner_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ldr_rdata   = ldr_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  // Value the bench places on a released Data_Bus; if the DUT also drives,
  // the resolved value no longer reads back as this pattern.
  localparam logic [7:0] KEEP = 8'h81;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=1 instance, index 1: WAIT_CYCLES=3 instance.
  logic       rst       [2];
  logic       cpu_req   [2];
  logic       cpu_rw    [2];
  logic [7:0] cpu_addr  [2];
  logic [7:0] cpu_wdata [2];
  logic       cpu_ack   [2];
  logic [7:0] cpu_rdata [2];
  logic       ldr_req   [2];
  logic       ldr_rw    [2];
  logic [7:0] ldr_addr  [2];
  logic [7:0] ldr_wdata [2];
  logic       ldr_ack   [2];
  logic [7:0] ldr_rdata [2];
  logic       owner     [2];
  logic [7:0] abus      [2];
  logic       rw        [2];
  logic       en        [2];
  logic       ale       [2];
  logic [7:0] mem_rd    [2];
  wire  [7:0] dbus0;
  wire  [7:0] dbus1;

  // Memory model: answers reads in the data phase, otherwise holds KEEP
  // except while the DUT should be driving a write.
  assign dbus0 = en[0] ? (rw[0] ? mem_rd[0] : 8'hzz) : KEEP;
  assign dbus1 = en[1] ? (rw[1] ? mem_rd[1] : 8'hzz) : KEEP;

  mem_bus_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst[0]),
    .cpu_req(cpu_req[0]), .cpu_rw(cpu_rw[0]), .cpu_addr(cpu_addr[0]),
    .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .ldr_req(ldr_req[0]), .ldr_rw(ldr_rw[0]), .ldr_addr(ldr_addr[0]),
    .ldr_wdata(ldr_wdata[0]), .ldr_ack(ldr_ack[0]), .ldr_rdata(ldr_rdata[0]),
    .owner(owner[0]), .Address_Bus(abus[0]), .Data_Bus(dbus0),
    .Rw(rw[0]), .En(en[0]), .ALE(ale[0])
  );

  mem_bus_arbiter #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[1]),
    .cpu_req(cpu_req[1]), .cpu_rw(cpu_rw[1]), .cpu_addr(cpu_addr[1]),
    .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .ldr_req(ldr_req[1]), .ldr_rw(ldr_rw[1]), .ldr_addr(ldr_addr[1]),
    .ldr_wdata(ldr_wdata[1]), .ldr_ack(ldr_ack[1]), .ldr_rdata(ldr_rdata[1]),
    .owner(owner[1]), .Address_Bus(abus[1]), .Data_Bus(dbus1),
    .Rw(rw[1]), .En(en[1]), .ALE(ale[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic exp_own [4];

  initial begin
`ifdef BUS_ARB_RR_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      cpu_req[i] = 1'b0; cpu_rw[i] = 1'b1; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      ldr_req[i] = 1'b0; ldr_rw[i] = 1'b1; ldr_addr[i] = '0; ldr_wdata[i] = '0;
      mem_rd[i] = '0;
    end
    cyc(2);

    // Reset state
    check("rst_abus", abus[0], 8'h00);
    check("rst_rw", 8'(rw[0]), 8'h01);
    check("rst_en", 8'(en[0]), 8'h00);
    check("rst_ale", 8'(ale[0]), 8'h00);
    check("rst_dbus", dbus0, KEEP);
    check("rst_cpu_ack", 8'(cpu_ack[0]), 8'h00);
    check("rst_ldr_ack", 8'(ldr_ack[0]), 8'h00);
    check("rst_cpu_rdata", cpu_rdata[0], 8'h00);
    check("rst_ldr_rdata", ldr_rdata[0], 8'h00);
    check("rst_owner", 8'(owner[0]), 8'h00);
    rst[0] = 1'b0; rst[1] = 1'b0;
    cyc(1);

    // CPU read 0x3C, W=1: ALE@1, En@2, ack@3
    cpu_req[0] = 1'b1; cpu_rw[0] = 1'b1; cpu_addr[0] = 8'h3C; mem_rd[0] = 8'hA5;
    cyc(1);
    check("t1_ale", 8'(ale[0]), 8'h01);
    check("t1_en_c1", 8'(en[0]), 8'h00);
    check("t1_abus", abus[0], 8'h3C);
    check("t1_rw", 8'(rw[0]), 8'h01);
    cyc(1);
    check("t1_en_c2", 8'(en[0]), 8'h01);
    check("t1_ale_c2", 8'(ale[0]), 8'h00);
    check("t1_ack_c2", 8'(cpu_ack[0]), 8'h00);
    cyc(1);
    check("t1_ack_c3", 8'(cpu_ack[0]), 8'h01);
    check("t1_en_c3", 8'(en[0]), 8'h00);
    check("t1_rdata", cpu_rdata[0], 8'hA5);
    check("t1_owner", 8'(owner[0]), 8'h00);
    check("t1_ldr_ack", 8'(ldr_ack[0]), 8'h00);
    cpu_req[0] = 1'b0;
    cyc(1);
    check("t1_ack_c4", 8'(cpu_ack[0]), 8'h00);

    // CPU read 0x44 with req dropped and addr changed during DATA
    cpu_req[0] = 1'b1; cpu_addr[0] = 8'h44; mem_rd[0] = 8'h6B;
    cyc(1);
    check("t4_ale", 8'(ale[0]), 8'h01);
    cyc(1);
    check("t4_en", 8'(en[0]), 8'h01);
    cpu_req[0] = 1'b0; cpu_addr[0] = 8'h99;
    #1 check("t4_abus_data", abus[0], 8'h44);
    cyc(1);
    check("t4_ack", 8'(cpu_ack[0]), 8'h01);
    check("t4_abus_ack", abus[0], 8'h44);
    check("t4_rdata", cpu_rdata[0], 8'h6B);
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      check("t4_ack_after", 8'(cpu_ack[0]), 8'h00);
      check("t4_ale_after", 8'(ale[0]), 8'h00);
      check("t4_en_after", 8'(en[0]), 8'h00);
    end

    // W=3 instance: CPU read 0x22 -> 0xC3, ack at cycle 5
    cpu_req[1] = 1'b1; cpu_rw[1] = 1'b1; cpu_addr[1] = 8'h22; mem_rd[1] = 8'hC3;
    cyc(4);
    check("b_ack_c4", 8'(cpu_ack[1]), 8'h00);
    cyc(1);
    check("b_ack_c5", 8'(cpu_ack[1]), 8'h01);
    check("b_rdata", cpu_rdata[1], 8'hC3);
    cpu_req[1] = 1'b0;
    cyc(1);

    // Loader write 0x7E to 0x10, W=3
    ldr_req[1] = 1'b1; ldr_rw[1] = 1'b0; ldr_addr[1] = 8'h10; ldr_wdata[1] = 8'h7E;
    cyc(1);
    check("t2_ale", 8'(ale[1]), 8'h01);
    check("t2_abus", abus[1], 8'h10);
    check("t2_rw_addr", 8'(rw[1]), 8'h00);
    check("t2_dbus_addr", dbus1, KEEP);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("t2_en", 8'(en[1]), 8'h01);
      check("t2_ale_data", 8'(ale[1]), 8'h00);
      check("t2_dbus", dbus1, 8'h7E);
      check("t2_rw", 8'(rw[1]), 8'h00);
      check("t2_ack_data", 8'(ldr_ack[1]), 8'h00);
    end
    cyc(1);
    check("t2_ldr_ack", 8'(ldr_ack[1]), 8'h01);
    check("t2_cpu_ack", 8'(cpu_ack[1]), 8'h00);
    check("t2_en_ack", 8'(en[1]), 8'h00);
    check("t2_dbus_ack", dbus1, KEEP);
    check("t2_owner", 8'(owner[1]), 8'h01);
    check("t2_cpu_rdata", cpu_rdata[1], 8'hC3);
    check("t2_ldr_rdata", ldr_rdata[1], 8'h00);
    ldr_req[1] = 1'b0;
    cyc(1);
    check("t2_ack_after", 8'(ldr_ack[1]), 8'h00);

    // Both requesters held high for 4 transactions (period 6, acks at 5,11,17,23)
    cpu_req[1] = 1'b1; cpu_rw[1] = 1'b0; cpu_addr[1] = 8'hA0; cpu_wdata[1] = 8'h11;
    ldr_req[1] = 1'b1; ldr_rw[1] = 1'b0; ldr_addr[1] = 8'hB0; ldr_wdata[1] = 8'h22;
    for (int k = 0; k < 4; k++) begin
      cyc((k == 0) ? 5 : 6);
      check("t3_owner", 8'(owner[1]), 8'(exp_own[k]));
      check("t3_cpu_ack", 8'(cpu_ack[1]), 8'(exp_own[k] == 1'b0));
      check("t3_ldr_ack", 8'(ldr_ack[1]), 8'(exp_own[k] == 1'b1));
      check("t3_abus", abus[1], exp_own[k] ? 8'hB0 : 8'hA0);
    end
    cpu_req[1] = 1'b0; ldr_req[1] = 1'b0;
    cyc(1);

    // Reset asserted during DATA of a CPU write
    cpu_req[1] = 1'b1; cpu_rw[1] = 1'b0; cpu_addr[1] = 8'h30; cpu_wdata[1] = 8'h55;
    cyc(2);
    check("t5_en", 8'(en[1]), 8'h01);
    check("t5_dbus", dbus1, 8'h55);
    #2 rst[1] = 1'b1;
    cpu_req[1] = 1'b0;
    #1;
    check("t5_rst_en", 8'(en[1]), 8'h00);
    check("t5_rst_ale", 8'(ale[1]), 8'h00);
    check("t5_rst_dbus", dbus1, KEEP);
    check("t5_rst_abus", abus[1], 8'h00);
    check("t5_rst_rw", 8'(rw[1]), 8'h01);
    check("t5_rst_owner", 8'(owner[1]), 8'h00);
    check("t5_rst_rdata", cpu_rdata[1], 8'h00);
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      check("t5_rst_ack", 8'(cpu_ack[1]), 8'h00);
    end
    rst[1] = 1'b0;
    cyc(1);
    check("t5_idle_ack", 8'(cpu_ack[1]), 8'h00);
    check("t5_idle_en", 8'(en[1]), 8'h00);

    // Fresh loader read after reset release
    ldr_req[1] = 1'b1; ldr_rw[1] = 1'b1; ldr_addr[1] = 8'h0F; mem_rd[1] = 8'h3A;
    cyc(1);
    check("t5_new_ale", 8'(ale[1]), 8'h01);
    check("t5_new_abus", abus[1], 8'h0F);
    cyc(3);
    check("t5_new_ack_c4", 8'(ldr_ack[1]), 8'h00);
    cyc(1);
    check("t5_new_ack", 8'(ldr_ack[1]), 8'h01);
    check("t5_new_rdata", ldr_rdata[1], 8'h3A);
    check("t5_new_owner", 8'(owner[1]), 8'h01);
    check("t5_new_cpu_ack", 8'(cpu_ack[1]), 8'h00);
    ldr_req[1] = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
